aclk_keypad_scan: RTL

AClk_KEYPAD_SCAN -- requirements
Module: aclk_keypad_scan

---
 rtl/aclk_keypad_scan_pkg.sv | 36 +++
 rtl/aclk_debounce_cnt.sv | 43 ++++
 rtl/aclk_keypad_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aclk_keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aclk_keypad_scan_pkg
// Purpose : Shared definitions for the alarm-clock keypad scanner: the NOKEY
//           code, FSM state encodings and the (row, column) to key-code map.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package aclk_keypad_scan_pkg;

  localparam logic [3:0] c_NOKEY = 4'hA;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_PRESS_DEB = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_DEB   = 2'd3
  } state_t;

  // Rows 0..2 carry digits 1..9 in reading order; row 3 is '*', '0', '#'.
  // '*' and '#' are not digits for the alarm clock and map to NOKEY.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = c_NOKEY;
    if (col <= 2'd2) begin
      if (row != 2'd3) begin
        code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
      end else if (col == 2'd1) begin
        code = 4'd0;
      end
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_debounce_cnt.sv
`default_nettype none
// ============================================================================
// Module  : aclk_debounce_cnt
// Purpose : 4-bit saturating debounce counter with target compare.
// Ports   : clk       - system clock
//           rst       - asynchronous active-high reset
//           i_load1   - start a new run (counter := 1)
//           i_inc     - one more matching sample (saturating increment)
//           o_reach   - the sample being counted now completes the run
// Revision: 1.0 - initial release
// ============================================================================
module aclk_debounce_cnt #(
  parameter int DEB_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load1,
  input  logic i_inc,
  output logic o_reach
);

  localparam logic [3:0] c_TARGET = 4'(DEB_SCANS);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : (r_cnt + 4'd1);
  // Compare against the post-increment value so the accepting sample is the
  // DEB_SCANS-th consecutive match, counting the first detection as one.
  assign o_reach   = (w_cnt_inc >= c_TARGET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_load1) begin
      r_cnt <= 4'd1;
    end else if (i_inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aclk_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module  : aclk_keypad_scan
// Purpose : 4x3 matrix keypad scanner with press/release debounce for the
//           alarm-clock key input.
// Ports   : clk       - system clock, rising edge
//           reset     - asynchronous active-high reset
//           col_n     - keypad columns, active-low, asynchronous
//           row_n     - keypad row drive, active-low one-cold
//           key       - held digit 0-9, or 4'hA when no digit is held
//           key_valid - one-cycle pulse when key becomes a digit
// Revision: 1.0 - initial release
// ============================================================================
module aclk_keypad_scan
  import aclk_keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 250,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [c_PW-1:0] r_presc;
  logic [2:0]      r_col_meta;
  logic [2:0]      r_col_s;
  logic [3:0]      r_row_n;
  logic [3:0]      r_key;
  logic [3:0]      r_cand;
  logic            r_key_valid;
  state_t          r_state;

  logic       w_tick;
  logic [1:0] w_row;
  logic       w_col_any;
  logic [1:0] w_col_idx;
  logic [3:0] w_digit;
  logic       w_digit_ok;
  logic       w_same;
  logic       w_deb_load1;
  logic       w_deb_inc;
  logic       w_deb_reach;

  assign row_n     = r_row_n;
  assign key       = r_key;
  assign key_valid = r_key_valid;

  // Free-running prescaler
  assign w_tick = (r_presc == c_PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Two-flop column synchroniser; idle value is all-high (pulled up)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_meta <= 3'b111;
      r_col_s    <= 3'b111;
    end else begin
      r_col_meta <= col_n;
      r_col_s    <= r_col_meta;
    end
  end

  // Row index of the single low bit in r_row_n, then lowest-column-wins decode
  always_comb begin
    w_row = 2'd0;
    case (r_row_n)
      4'b1101: w_row = 2'd1;
      4'b1011: w_row = 2'd2;
      4'b0111: w_row = 2'd3;
      default: w_row = 2'd0;
    endcase
  end

  always_comb begin
    w_col_any = ~&r_col_s;
    w_col_idx = 2'd2;
    if (!r_col_s[0]) begin
      w_col_idx = 2'd0;
    end else if (!r_col_s[1]) begin
      w_col_idx = 2'd1;
    end
    w_digit    = w_col_any ? key_map(w_row, w_col_idx) : c_NOKEY;
    w_digit_ok = (w_digit != c_NOKEY);
    w_same     = w_digit_ok && (w_digit == r_cand);
  end

  assign w_deb_load1 = w_tick && (((r_state == ST_SCAN) && w_digit_ok) ||
                                  ((r_state == ST_HELD) && !w_col_any));
  assign w_deb_inc   = w_tick && (((r_state == ST_PRESS_DEB) && w_same) ||
                                  ((r_state == ST_REL_DEB) && !w_col_any));

  aclk_debounce_cnt #(
    .DEB_SCANS (DEB_SCANS)
  ) u_deb (
    .clk     (clk),
    .rst     (reset),
    .i_load1 (w_deb_load1),
    .i_inc   (w_deb_inc),
    .o_reach (w_deb_reach)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_row_n     <= 4'b1110;
      r_key       <= c_NOKEY;
      r_cand      <= c_NOKEY;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_digit_ok) begin
              r_cand  <= w_digit;
              r_state <= ST_PRESS_DEB;
            end else begin
              r_row_n <= {r_row_n[2:0], r_row_n[3]};
            end
          end
          ST_PRESS_DEB: begin
            if (w_same) begin
              if (w_deb_reach) begin
                r_key       <= r_cand;
                r_key_valid <= 1'b1;
                r_state     <= ST_HELD;
              end
            end else begin
              r_state <= ST_SCAN;
              r_row_n <= {r_row_n[2:0], r_row_n[3]};
            end
          end
          ST_HELD: begin
            // Any other key on this row is ignored; only a full release counts
            if (!w_col_any) begin
              r_state <= ST_REL_DEB;
            end
          end
          ST_REL_DEB: begin
            if (w_col_any) begin
              r_state <= ST_HELD;
            end else if (w_deb_reach) begin
              r_key   <= c_NOKEY;
              r_state <= ST_SCAN;
              r_row_n <= {r_row_n[2:0], r_row_n[3]};
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
